// File: rtl/noc_flit_pkg.sv
// Shared flit-type encodings, error codes and per-VC framing states
// for the ejection-side packet monitor.
package noc_flit_pkg;

    localparam logic [1:0] HEAD    = 2'b01;
    localparam logic [1:0] BODY    = 2'b00;
    localparam logic [1:0] TAIL    = 2'b11;
    localparam logic [1:0] ILLEGAL = 2'b10;

    typedef enum logic [2:0] {
        NONE        = 3'd0,
        HEAD_IN_PKT = 3'd1,
        BODY_IDLE   = 3'd2,
        LEN         = 3'd3,
        ILLEGAL_ID  = 3'd4
    } err_code_t;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } vc_state_t;

endpackage

// File: rtl/flit_pipe_reg.sv
// One-entry valid/ready pipeline register; reloads on the same
// cycle it drains so a back-to-back stream runs at one flit per cycle.
module flit_pipe_reg #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    input  logic             ready_out
);

    // Space is available when empty or when the held entry leaves now.
    assign ready_in = ~valid_out | ready_out;

    // Load on accept; the payload holds while stalled or drained empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else if (ready_in) begin
            valid_out <= valid_in;
            if (valid_in) begin
                data_out <= data_in;
            end
        end
    end

endmodule

// File: rtl/eject_packet_monitor.sv
// Ejection stage: forwards flits tagged with their VC and checks
// per-VC packet framing, counting packets and latching the first error.
module eject_packet_monitor
    import noc_flit_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int VC               = 4,
    parameter int IDENTIFIER_BITS  = 2,
    parameter int FLITS_PER_PACKET = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [$clog2(VC)-1:0] vc_sel,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [$clog2(VC)-1:0] vc_out,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic [31:0]           packets_ejected,
    output logic                  error,
    output logic [2:0]            error_code,
    output logic [$clog2(VC)-1:0] error_vc
);

    localparam int VW = $clog2(VC);
    localparam int CW = $clog2(FLITS_PER_PACKET) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FLITS_PER_PACKET);

    logic                       accept;
    logic [IDENTIFIER_BITS-1:0] ftype;
    logic [VW+DATA_WIDTH-1:0]   pipe_q;

    vc_state_t       st  [VC];
    logic [CW-1:0]   cnt [VC];

    vc_state_t       cur_st;
    logic [CW-1:0]   cur_cnt;
    vc_state_t       st_nxt;
    logic [CW-1:0]   cnt_nxt;
    logic [CW-1:0]   cnt_inc;
    err_code_t       code_nxt;
    logic            pkt_done;
    err_code_t       err_q;

    flit_pipe_reg #(
        .WIDTH(VW + DATA_WIDTH)
    ) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .data_in  ({vc_sel, data_in}),
        .valid_in (valid_in),
        .ready_in (ready_in),
        .data_out (pipe_q),
        .valid_out(valid_out),
        .ready_out(ready_out)
    );

    assign vc_out   = pipe_q[VW+DATA_WIDTH-1 -: VW];
    assign data_out = pipe_q[DATA_WIDTH-1:0];
    assign accept   = valid_in & ready_in;
    assign ftype    = data_in[DATA_WIDTH-1 -: IDENTIFIER_BITS];

    // Framing transition for the VC of the flit being offered.
    // The counter saturates so an overlong packet can never wrap
    // back onto the legal length and hide its LEN error.
    always_comb begin
        cur_st   = st[vc_sel];
        cur_cnt  = cnt[vc_sel];
        cnt_inc  = (cur_cnt == CNT_MAX) ? cur_cnt : cur_cnt + 1'b1;
        st_nxt   = cur_st;
        cnt_nxt  = cur_cnt;
        code_nxt = NONE;
        pkt_done = 1'b0;
        if (ftype == ILLEGAL) begin
            code_nxt = ILLEGAL_ID;
        end else if (cur_st == IDLE) begin
            if (ftype == HEAD) begin
                st_nxt  = IN_PKT;
                cnt_nxt = CW'(1);
            end else begin
                code_nxt = BODY_IDLE;
            end
        end else begin
            unique case (ftype)
                HEAD: begin
                    code_nxt = HEAD_IN_PKT;
                    cnt_nxt  = CW'(1);
                end
                TAIL: begin
                    st_nxt   = IDLE;
                    pkt_done = 1'b1;
                    if (cur_cnt + 1'b1 != CNT_MAX) begin
                        code_nxt = LEN;
                    end
                end
                default: cnt_nxt = cnt_inc;
            endcase
        end
    end

    // Per-VC framing state, updated only for the accepted flit's VC.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < VC; i++) begin
                st[i]  <= IDLE;
                cnt[i] <= '0;
            end
        end else if (accept) begin
            st[vc_sel]  <= st_nxt;
            cnt[vc_sel] <= cnt_nxt;
        end
    end

    // Packet count and sticky first-error capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            packets_ejected <= '0;
            error           <= 1'b0;
            err_q           <= NONE;
            error_vc        <= '0;
        end else if (accept) begin
            if (pkt_done) begin
                packets_ejected <= packets_ejected + 32'd1;
            end
            if (code_nxt != NONE && !error) begin
                error    <= 1'b1;
                err_q    <= code_nxt;
                error_vc <= vc_sel;
            end
        end
    end

    assign error_code = err_q;

endmodule
